// File: rtl/cheri_tsmap_arbiter.sv
// cheri_tsmap_arbiter: shares the revocation-bitmap SRAM between trvk reads, sweep clears and bus accesses
module cheri_tsmap_arbiter #(
  parameter int unsigned TSMapSize    = 1024,
  parameter bit          ClearOnReset = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trvk_cs_i,
  input  logic [15:0] trvk_addr_i,
  output logic [31:0] trvk_rdata_o,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [15:0] bus_addr_i,
  input  logic [3:0]  bus_be_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_gnt_o,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic        bus_err_o,
  input  logic        clr_start_i,
  output logic        clr_busy_o,
  output logic        clr_done_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  localparam int unsigned PW = $clog2(TSMapSize) + 1;
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] clr_ptr_q, clr_ptr_d;
  logic init_q, init_d;
  logic done_q, done_d;
  logic trvk_pend_q, trvk_pend_d;
  logic trvk_mask_q, trvk_mask_d;
  logic [31:0] trvk_hold_q, trvk_hold_d;
  logic bus_pend_q, bus_pend_d;
  logic bus_err_q, bus_err_d;
  logic bus_rd_q, bus_rd_d;
  logic busy, sweep_we, bus_ok, bus_acc, last, start;
  always_comb begin
    busy = state_q == CLEAR;
    sweep_we = busy & ~trvk_cs_i;
    bus_gnt_o = bus_req_i & ~trvk_cs_i & ~busy;
    bus_ok = 32'(bus_addr_i) < TSMapSize;
    bus_acc = bus_gnt_o & bus_ok;
    last = 32'(clr_ptr_q) == TSMapSize - 1;
    start = clr_start_i | (init_q & ClearOnReset);
    init_d = 1'b0;
    state_d = busy ? ((sweep_we & last) ? IDLE : CLEAR) : (start ? CLEAR : IDLE);
    clr_ptr_d = busy ? (sweep_we ? clr_ptr_q + PW'(1) : clr_ptr_q) : (start ? '0 : clr_ptr_q);
    done_d = sweep_we & last;
    mem_cs_o = trvk_cs_i | sweep_we | bus_acc;
    mem_we_o = ~trvk_cs_i & (sweep_we | (bus_acc & bus_we_i));
    mem_addr_o = trvk_cs_i ? trvk_addr_i : sweep_we ? 16'(clr_ptr_q) : bus_acc ? bus_addr_i : '0;
    mem_be_o = (trvk_cs_i | sweep_we) ? 4'hF : bus_acc ? bus_be_i : '0;
    mem_wdata_o = (bus_acc & bus_we_i) ? bus_wdata_i : '0;
    trvk_pend_d = trvk_cs_i;
    trvk_mask_d = trvk_cs_i & busy & (32'(trvk_addr_i) >= 32'(clr_ptr_q));
    trvk_rdata_o = trvk_pend_q ? (trvk_mask_q ? '0 : mem_rdata_i) : trvk_hold_q;
    trvk_hold_d = trvk_rdata_o;
    bus_pend_d = bus_gnt_o;
    bus_err_d = bus_gnt_o & ~bus_ok;
    bus_rd_d = bus_acc & ~bus_we_i;
    bus_rvalid_o = bus_pend_q;
    bus_err_o = bus_err_q;
    bus_rdata_o = bus_rd_q ? mem_rdata_i : '0;
    clr_busy_o = busy;
    clr_done_o = done_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      clr_ptr_q <= '0;
      init_q <= 1'b1;
      done_q <= 1'b0;
      trvk_pend_q <= 1'b0;
      trvk_mask_q <= 1'b0;
      trvk_hold_q <= '0;
      bus_pend_q <= 1'b0;
      bus_err_q <= 1'b0;
      bus_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      init_q <= init_d;
      done_q <= done_d;
      trvk_pend_q <= trvk_pend_d;
      trvk_mask_q <= trvk_mask_d;
      trvk_hold_q <= trvk_hold_d;
      bus_pend_q <= bus_pend_d;
      bus_err_q <= bus_err_d;
      bus_rd_q <= bus_rd_d;
    end
  end
endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// tb_cheri_tsmap_arbiter: scoreboard bench with a word-level map model and SRAM model
module tb_cheri_tsmap_arbiter;
  localparam int N = 1024;
  localparam int AW = $clog2(N);
  typedef struct { int cyc; logic err; logic [31:0] data; } rsp_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic trvk_cs_i = 1'b0;
  logic [15:0] trvk_addr_i = '0;
  logic [31:0] trvk_rdata_o;
  logic bus_req_i = 1'b0;
  logic bus_we_i = 1'b0;
  logic [15:0] bus_addr_i = '0;
  logic [3:0] bus_be_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic bus_gnt_o, bus_rvalid_o, bus_err_o;
  logic [31:0] bus_rdata_o;
  logic clr_start_i = 1'b0;
  logic clr_busy_o, clr_done_o;
  logic mem_cs_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cur_cyc = -1;
  logic cur_busy, cur_done, cur_gnt;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_init = 1'b0;
  int m_left = 0;
  logic [31:0] ref_map [N];
  logic [31:0] sram [N];
  logic [31:0] hold = '0;
  rsp_t trvk_q[$];
  rsp_t bus_q[$];
  cheri_tsmap_arbiter #(.TSMapSize(N), .ClearOnReset(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .trvk_cs_i(trvk_cs_i), .trvk_addr_i(trvk_addr_i), .trvk_rdata_o(trvk_rdata_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_be_i(bus_be_i),
    .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o),
    .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o),
    .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      foreach (sram[i]) sram[i] <= $urandom | 32'h1;
    end else if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b] && 32'(mem_addr_o) < N) sram[mem_addr_o[AW-1:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= (32'(mem_addr_o) < N) ? sram[mem_addr_o[AW-1:0]] : 32'hDEAD_BEEF;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, act, exp);
    end
  endtask
  always @(negedge clk_i) begin : monitor
    rsp_t r;
    if (!rst_ni) begin
      trvk_q.delete();
      bus_q.delete();
      hold = '0;
    end else begin
      if (trvk_q.size() > 0 && trvk_q[0].cyc == cyc - 1) begin
        r = trvk_q.pop_front();
        hold = r.data;
        chk("trvk_rdata", trvk_rdata_o, hold);
      end else begin
        chk("trvk_hold", trvk_rdata_o, hold);
      end
      if (bus_rvalid_o) begin
        if (bus_q.size() > 0 && bus_q[0].cyc == cyc - 1) begin
          r = bus_q.pop_front();
          chk("bus_rdata", bus_rdata_o, r.data);
          chk("bus_err", 32'(bus_err_o), 32'(r.err));
        end else begin
          chk("bus_rvalid_spurious", 32'(bus_rvalid_o), 32'd0);
        end
      end else if (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
        void'(bus_q.pop_front());
        chk("bus_rvalid_missing", 32'(bus_rvalid_o), 32'd1);
      end
      if (cur_cyc == cyc) begin
        chk("clr_busy", 32'(clr_busy_o), 32'(cur_busy));
        chk("clr_done", 32'(clr_done_o), 32'(cur_done));
        chk("bus_gnt", 32'(bus_gnt_o), 32'(cur_gnt));
      end
    end
  end
  task automatic model_eval();
    logic g;
    logic [AW-1:0] a;
    cur_cyc = cyc;
    cur_busy = m_busy;
    cur_done = m_done;
    g = bus_req_i & ~trvk_cs_i & ~m_busy;
    cur_gnt = g;
    if (trvk_cs_i) trvk_q.push_back('{cyc, 1'b0, ref_map[trvk_addr_i[AW-1:0]]});
    if (g) begin
      a = bus_addr_i[AW-1:0];
      if (32'(bus_addr_i) >= N) begin
        bus_q.push_back('{cyc, 1'b1, 32'd0});
        #1 chk("oor_mem_cs", 32'(mem_cs_o), 32'd0);
      end else if (bus_we_i) begin
        for (int b = 0; b < 4; b++) if (bus_be_i[b]) ref_map[a][8*b +: 8] = bus_wdata_i[8*b +: 8];
        bus_q.push_back('{cyc, 1'b0, 32'd0});
      end else begin
        bus_q.push_back('{cyc, 1'b0, ref_map[a]});
      end
    end
    m_done = 1'b0;
    if (m_busy) begin
      if (!trvk_cs_i) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (clr_start_i || m_init) begin
      m_busy = 1'b1;
      m_left = N;
      foreach (ref_map[i]) ref_map[i] = '0;
    end
    m_init = 1'b0;
  endtask
  task automatic step(input logic t, input logic [15:0] ta, input logic br, input logic bw,
                      input logic [15:0] ba, input logic [3:0] bb, input logic [31:0] bd, input logic cs);
    @(posedge clk_i);
    #1;
    trvk_cs_i = t;
    trvk_addr_i = ta;
    bus_req_i = br;
    bus_we_i = bw;
    bus_addr_i = ba;
    bus_be_i = bb;
    bus_wdata_i = bd;
    clr_start_i = cs;
    model_eval();
  endtask
  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    trvk_cs_i = 1'b0;
    bus_req_i = 1'b0;
    clr_start_i = 1'b0;
    #1;
    chk("rst_busy", 32'(clr_busy_o), 32'd0);
    chk("rst_done", 32'(clr_done_o), 32'd0);
    chk("rst_trvk_rdata", trvk_rdata_o, 32'd0);
    chk("rst_rvalid", 32'(bus_rvalid_o), 32'd0);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_init = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_eval();
  endtask
  task automatic bus_op(input logic we, input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    do begin
      step(1'b0, '0, 1'b1, we, a, be, d, 1'b0);
      n++;
    end while (!cur_gnt && n < 3000);
    if (!cur_gnt) chk("bus_grant_timeout", 32'(bus_gnt_o), 32'd1);
    idle();
  endtask
  task automatic wait_sweep(output int busy_cnt, output int done_cnt);
    int n = 0;
    busy_cnt = 0;
    done_cnt = 0;
    do begin
      idle();
      busy_cnt += int'(clr_busy_o);
      done_cnt += int'(clr_done_o);
      n++;
    end while (!cur_done && n < 3000);
    if (!cur_done) chk("sweep_timeout", 32'(clr_busy_o), 32'd0);
    repeat (3) begin
      idle();
      done_cnt += int'(clr_done_o);
    end
  endtask
  initial begin
    int bc, dc;
    logic b_act, b_we;
    logic [15:0] b_addr;
    logic [3:0] b_be;
    logic [31:0] b_d;
    #1 rst_ni = 1'b0;
    do_reset();
    wait_sweep(bc, dc);
    chk("reset_sweep_busy_cycles", bc, 32'd1024);
    chk("reset_sweep_done_pulses", dc, 32'd1);
    for (int i = 0; i < N; i++) step(1'b1, 16'(i), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    idle();
    bus_op(1'b1, 16'd5, 4'b0011, 32'hA5A5_0F0F);
    bus_op(1'b0, 16'd5, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(i), 1'b1, 1'b0, 16'd5, 4'h0, '0, 1'b0);
    bus_op(1'b0, 16'd5, 4'h0, 32'h0);
    bus_op(1'b1, 16'd900, 4'hF, 32'hFFFF_FFFF);
    bus_op(1'b0, 16'd900, 4'h0, 32'h0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (100) idle();
    step(1'b1, 16'd900, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 16'd50, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 16'd899, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    repeat (50) idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    wait_sweep(bc, dc);
    chk("restart_ignored_done_pulses", dc, 32'd1);
    step(1'b1, 16'd900, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    bus_op(1'b0, 16'd1024, 4'h0, 32'h0);
    bus_op(1'b1, 16'hFFFF, 4'hF, 32'h1234_5678);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (200) idle();
    do_reset();
    dc = 0;
    repeat (500) begin
      idle();
      dc += int'(clr_done_o);
    end
    chk("abort_no_done", dc, 32'd0);
    wait_sweep(bc, dc);
    b_act = 1'b0;
    b_we = 1'b0;
    b_addr = '0;
    b_be = '0;
    b_d = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!b_act && $urandom_range(0, 9) < 4) begin
        b_act = 1'b1;
        b_we = 1'($urandom_range(0, 1));
        b_addr = ($urandom_range(0, 7) == 0) ? 16'(N + $urandom_range(0, 200)) : 16'($urandom_range(0, 31));
        b_be = 4'($urandom);
        b_d = $urandom;
      end
      step($urandom_range(0, 9) < 3, ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, N - 1)),
           b_act, b_we, b_addr, b_be, b_d, $urandom_range(0, 799) == 0);
      if (cur_gnt) b_act = 1'b0;
    end
    if (b_act) bus_op(b_we, b_addr, b_be, b_d);
    repeat (4) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
